// File: rtl/cash_arbiter.sv
// Round-robin arbiter/sequencer sharing one cache port among N clients.
// One outstanding access; the watchdog ends WAIT with rsp_err.
module cash_arbiter #(
  parameter int requesters    = 4,
  parameter int address_size  = 4,
  parameter int data_size     = 4,
  parameter int timeout_width = 4,
  localparam int IW = $clog2(requesters)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [requesters-1:0]              req,
  input  logic [requesters-1:0]              req_action,
  input  logic [requesters*address_size-1:0] req_address,
  input  logic [requesters*data_size-1:0]    req_data,
  output logic [requesters-1:0]              ack,
  output logic [data_size-1:0]               rsp_data,
  output logic                               rsp_hit,
  output logic                               rsp_err,
  output logic                               busy,
  output logic [IW-1:0]                      grant_id,
  output logic                               cash_valid,
  output logic                               cash_action,
  output logic [address_size-1:0]            cash_address,
  output logic [data_size-1:0]               cash_data,
  input  logic                               cash_done,
  input  logic [data_size-1:0]               cash_rdata,
  input  logic                               cash_hit
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                    r_state;
  logic [IW-1:0]             r_last;
  logic [IW-1:0]             r_grant;
  logic [timeout_width-1:0]  r_wd;
  logic [requesters-1:0]     r_ack;
  logic [data_size-1:0]      r_rsp_data;
  logic                      r_rsp_hit;
  logic                      r_rsp_err;
  logic                      r_busy;
  logic                      r_valid;
  logic                      r_action;
  logic [address_size-1:0]   r_addr;
  logic [data_size-1:0]      r_data;

  logic [address_size-1:0]   w_addr [requesters];
  logic [data_size-1:0]      w_data [requesters];
  logic [requesters-1:0]     w_grant_oh;
  logic [IW:0]               w_sum;
  logic [IW-1:0]             w_idx;
  logic [IW-1:0]             w_pick;
  logic                      w_found;

  for (genvar g = 0; g < requesters; g++) begin : g_unpack
    assign w_addr[g] = req_address[g*address_size +: address_size];
    assign w_data[g] = req_data[g*data_size +: data_size];
  end

  assign w_grant_oh = {{(requesters-1){1'b0}}, 1'b1} << r_grant;

  // Walk downward so the lowest offset from last+1 is the final winner.
  always_comb begin
    w_sum   = '0;
    w_idx   = '0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = requesters - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_last} + (IW+1)'(k + 1);
      if (w_sum >= (IW+1)'(requesters))
        w_sum = w_sum - (IW+1)'(requesters);
      w_idx = w_sum[IW-1:0];
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= IW'(requesters - 1);
      r_grant    <= '0;
      r_wd       <= '0;
      r_ack      <= '0;
      r_rsp_data <= '0;
      r_rsp_hit  <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_action   <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ack   <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_ISSUE;
            r_busy   <= 1'b1;
            r_grant  <= w_pick;
            r_last   <= w_pick;
            r_valid  <= 1'b1;
            r_action <= req_action[w_pick];
            r_addr   <= w_addr[w_pick];
            r_data   <= w_data[w_pick];
          end
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (cash_done) begin
            r_rsp_data <= cash_rdata;
            r_rsp_hit  <= cash_hit;
            r_rsp_err  <= 1'b0;
            r_ack      <= w_grant_oh;
            r_state    <= S_RESP;
          end else if (&r_wd) begin
            r_rsp_data <= '0;
            r_rsp_hit  <= 1'b0;
            r_rsp_err  <= 1'b1;
            r_ack      <= w_grant_oh;
            r_state    <= S_RESP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack          = r_ack;
  assign rsp_data     = r_rsp_data;
  assign rsp_hit      = r_rsp_hit;
  assign rsp_err      = r_rsp_err;
  assign busy         = r_busy;
  assign grant_id     = r_grant;
  assign cash_valid   = r_valid;
  assign cash_action  = r_action;
  assign cash_address = r_addr;
  assign cash_data    = r_data;

endmodule

// File: tb/tb_cash_arbiter.sv
// Scoreboard bench for cash_arbiter: directed client traffic,
// behavioural cache, expected acks queued at request time.
module tb_cash_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_action;
  logic [15:0] req_address;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  rsp_data;
  logic        rsp_hit;
  logic        rsp_err;
  logic        busy;
  logic [1:0]  grant_id;
  logic        cash_valid;
  logic        cash_action;
  logic [3:0]  cash_address;
  logic [3:0]  cash_data;
  logic        cash_done;
  logic [3:0]  cash_rdata;
  logic        cash_hit;

  cash_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_action(req_action),
    .req_address(req_address), .req_data(req_data), .ack(ack),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id), .cash_valid(cash_valid),
    .cash_action(cash_action), .cash_address(cash_address),
    .cash_data(cash_data), .cash_done(cash_done),
    .cash_rdata(cash_rdata), .cash_hit(cash_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] d;
    logic       h;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_ack = 0;
  int   last_ack_cyc = 0;
  int   prev_ack_cyc = 0;
  bit   prev_valid = 0;
  bit   spacing = 0;
  int   hold_cnt = 0;
  int   cache_delay = 1;
  bit   pend = 0;
  int   cnt = 0;
  logic [3:0] p_addr = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Cache model: done arrives cache_delay negedges after the strobe, 0 = never.
  always @(negedge clk) begin
    cash_done = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          cash_done = 1'b1;
          cash_rdata = p_addr ^ 4'hF;
          cash_hit = p_addr[0];
        end
      end
      if (cash_valid && cache_delay > 0) begin
        pend = 1;
        cnt = cache_delay;
        p_addr = cash_address;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ack != 4'b0) begin
      exp_t e;
      n_ack++;
      if (spacing && prev_valid)
        check("ack_gap", cyc - prev_ack_cyc, 4);
      prev_ack_cyc = cyc;
      prev_valid = 1;
      last_ack_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexp_ack", {28'b0, ack}, 0);
      end else begin
        e = sb.pop_front();
        check("ack", {28'b0, ack}, 32'(1 << e.id));
        check("grant_id", {30'b0, grant_id}, e.id);
        check("rsp_data", {28'b0, rsp_data}, {28'b0, e.d});
        check("rsp_hit", {31'b0, rsp_hit}, {31'b0, e.h});
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
      end
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) req = '0;
      end else begin
        req = req & ~ack;
      end
    end
  end

  task automatic issue(input int id, input logic act, input logic [3:0] a,
                       input logic [3:0] d, input bit to);
    exp_t e;
    req_action[id] = act;
    req_address[id*4 +: 4] = a;
    req_data[id*4 +: 4] = d;
    e.id = id;
    e.d = to ? 4'h0 : (a ^ 4'hF);
    e.h = to ? 1'b0 : a[0];
    e.e = to;
    sb.push_back(e);
    req[id] = 1'b1;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    bit done = 0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1;
    end
    if (!done) begin
      check({tag, "_timeout"}, 1, 0);
      sb.delete();
    end
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_ack"}, {28'b0, ack}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_grant"}, {30'b0, grant_id}, 0);
    check({tag, "_valid"}, {31'b0, cash_valid}, 0);
    check({tag, "_caddr"}, {28'b0, cash_address}, 0);
    check({tag, "_rsp"}, {26'b0, rsp_data, rsp_hit, rsp_err}, 0);
  endtask

  int t0;
  int a0;

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_action = '0;
    req_address = '0;
    req_data = '0;
    cash_done = 1'b0;
    cash_rdata = '0;
    cash_hit = 1'b0;
    repeat (3) @(negedge clk);
    reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // single read, client 2
    cache_delay = 1;
    t0 = cyc;
    issue(2, 1'b0, 4'h5, 4'h0, 0);
    @(negedge clk);
    check("rd_valid", {31'b0, cash_valid}, 1);
    check("rd_addr", {28'b0, cash_address}, 5);
    check("rd_act", {31'b0, cash_action}, 0);
    check("rd_busy", {31'b0, busy}, 1);
    @(negedge clk);
    check("rd_valid_pulse", {31'b0, cash_valid}, 0);
    check("rd_addr_hold", {28'b0, cash_address}, 5);
    wait_idle(20, "rd");
    check("rd_latency", last_ack_cyc - t0, 3);

    // rotation after skip
    issue(1, 1'b0, 4'h2, 4'h0, 0);
    wait_idle(20, "rot1");
    issue(3, 1'b0, 4'h7, 4'h0, 0);
    issue(0, 1'b1, 4'hB, 4'h3, 0);
    wait_idle(30, "rot2");

    // watchdog timeout on a write, then a normal access
    cache_delay = 0;
    t0 = cyc;
    issue(0, 1'b1, 4'h9, 4'h6, 1);
    @(negedge clk);
    check("to_act", {31'b0, cash_action}, 1);
    check("to_data", {28'b0, cash_data}, 6);
    wait_idle(40, "to");
    check("to_latency", last_ack_cyc - (t0 + 1), 17);
    cache_delay = 1;
    issue(1, 1'b0, 4'h3, 4'h0, 0);
    wait_idle(20, "post_to");

    // withdrawal while busy
    cache_delay = 3;
    a0 = n_ack;
    issue(0, 1'b0, 4'h4, 4'h0, 0);
    @(negedge clk);
    @(negedge clk);
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    wait_idle(20, "wd");
    repeat (6) @(negedge clk);
    check("wd_acks", n_ack - a0, 1);
    check("wd_grant", {30'b0, grant_id}, 0);

    // reset during WAIT
    cache_delay = 0;
    a0 = n_ack;
    req_address[15:12] = 4'h8;
    req[3] = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    req = '0;
    #1;
    reset_outputs("mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_noack", n_ack - a0, 0);

    // fairness with all clients held
    cache_delay = 1;
    a0 = n_ack;
    prev_valid = 0;
    spacing = 1;
    hold_cnt = 5;
    issue(0, 1'b0, 4'h1, 4'h0, 0);
    issue(1, 1'b0, 4'h6, 4'h0, 0);
    issue(2, 1'b0, 4'hD, 4'h0, 0);
    issue(3, 1'b0, 4'hE, 4'h0, 0);
    sb.push_back('{0, 4'hE, 1'b1, 1'b0});
    wait_idle(60, "fair");
    spacing = 0;
    check("fair_acks", n_ack - a0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
